// File: rtl/intr_ctrl_gen.sv
// ============================================================================
// intr_ctrl_gen : edge-captured interrupt controller, table-priority or
//                 round-robin dispatch, vector/EOI handshake with watchdog
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module intr_ctrl_gen #(
    parameter int                    N_CH    = 8,
    parameter int                    ID_W    = 3,
    parameter int                    BUS_W   = 8,
    parameter logic [BUS_W-ID_W-1:0] VEC_TAG = 5'b10011,
    parameter logic [BUS_W-ID_W-1:0] EOI_TAG = 5'b01100,
    parameter int                    TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [N_CH-1:0]  intr_rq,
    input  logic [N_CH-1:0]  mask_in,
    input  logic             cmd_valid,
    input  logic [BUS_W-1:0] bus_in,
    input  logic             intr_in,
    output logic             intr_out,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic [N_CH-1:0]  pending,
    output logic             err
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_CFG    = 3'd0,
        S_ARB    = 3'd1,
        S_ASSERT = 3'd2,
        S_ACK    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_RR   = 2'd1,
        MODE_PRI  = 2'd2
    } mode_t;

    state_t          state, state_nxt;
    mode_t           mode;
    logic [ID_W-1:0] prio_tbl [N_CH];
    logic [ID_W-1:0] rr_ptr, cur_id, load_idx;
    logic [ID_W-1:0] pri_id, rr_id, win_id, cand;
    logic            pri_hit, rr_hit, win_found;
    logic [N_CH-1:0] rq_prev, elig, eoi_clr;
    logic [TMR_W-1:0] timer;
    logic            wd_due, dispatch, eoi_ok, eoi_bad, wd_fire;
    logic            tbl_wr, set_rr, set_pri;

    assign elig   = pending & ~mask_in;
    assign wd_due = (TIMEOUT != 0) && (timer == TMR_MAX);

    // Loops run from the far end so the nearest candidate is the last assignment.
    always_comb begin
        pri_id  = '0;
        pri_hit = 1'b0;
        rr_id   = '0;
        rr_hit  = 1'b0;
        cand    = '0;
        for (int r = N_CH - 1; r >= 0; r--) begin
            if (elig[prio_tbl[r]]) begin
                pri_id  = prio_tbl[r];
                pri_hit = 1'b1;
            end
        end
        for (int k = N_CH; k >= 1; k--) begin
            cand = rr_ptr + ID_W'(k);
            if (elig[cand]) begin
                rr_id  = cand;
                rr_hit = 1'b1;
            end
        end
        win_id    = (mode == MODE_PRI) ? pri_id : rr_id;
        win_found = (mode == MODE_PRI) ? pri_hit : ((mode == MODE_RR) ? rr_hit : 1'b0);
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= S_CFG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dispatch  = 1'b0;
        eoi_ok    = 1'b0;
        eoi_bad   = 1'b0;
        wd_fire   = 1'b0;
        tbl_wr    = 1'b0;
        set_rr    = 1'b0;
        set_pri   = 1'b0;
        case (state)
            S_CFG: begin
                if (cmd_valid && bus_in[1:0] == 2'b01) begin
                    set_rr    = 1'b1;
                    state_nxt = S_ARB;
                end else if (cmd_valid && bus_in[1:0] == 2'b10) begin
                    tbl_wr = 1'b1;
                    if (load_idx == LAST_IDX) begin
                        set_pri   = 1'b1;
                        state_nxt = S_ARB;
                    end
                end
            end
            S_ARB: begin
                if (cmd_valid && bus_in == {BUS_W{1'b1}}) begin
                    state_nxt = S_CFG;
                end else if (win_found) begin
                    dispatch  = 1'b1;
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (!intr_in) begin
                    state_nxt = S_ACK;
                end else if (wd_due) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_ARB;
                end
            end
            S_ACK: begin
                if (!intr_in) begin
                    state_nxt = S_DONE;
                end else if (wd_due) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_ARB;
                end
            end
            S_DONE: begin
                if (cmd_valid && !intr_in) begin
                    if (bus_in == {EOI_TAG, cur_id}) begin
                        eoi_ok    = 1'b1;
                        state_nxt = S_ARB;
                    end else begin
                        eoi_bad   = 1'b1;
                        state_nxt = S_CFG;
                    end
                end else if (wd_due) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_ARB;
                end
            end
            default: state_nxt = S_CFG;
        endcase
    end

    assign eoi_clr = eoi_ok ? (N_CH'(1) << cur_id) : '0;

    // Handshake outputs are pure functions of the upcoming state, so any exit
    // (advance, watchdog, reset) drops them in step with the state register.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            mode     <= MODE_NONE;
            rr_ptr   <= LAST_IDX;
            cur_id   <= '0;
            load_idx <= '0;
            timer    <= '0;
            rq_prev  <= '0;
            pending  <= '0;
            intr_out <= 1'b0;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
            err      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                prio_tbl[i] <= ID_W'(i);
            end
        end else begin
            rq_prev  <= intr_rq;
            pending  <= (pending & ~eoi_clr) | (intr_rq & ~rq_prev);
            err      <= eoi_bad | wd_fire;
            intr_out <= (state_nxt == S_ASSERT);
            bus_oe   <= (state_nxt == S_ACK);
            bus_out  <= (state_nxt == S_ACK) ? {VEC_TAG, cur_id} : '0;

            if (set_rr) begin
                mode <= MODE_RR;
            end else if (set_pri) begin
                mode <= MODE_PRI;
            end

            if (tbl_wr) begin
                prio_tbl[load_idx] <= bus_in[ID_W+1:2];
            end

            if (state_nxt == S_CFG && state != S_CFG) begin
                load_idx <= '0;
            end else if (tbl_wr) begin
                load_idx <= load_idx + 1'b1;
            end

            if (dispatch) begin
                cur_id <= win_id;
            end

            if (eoi_ok && mode == MODE_RR) begin
                rr_ptr <= cur_id;
            end

            if (state_nxt != state) begin
                timer <= '0;
            end else if (state == S_ASSERT || state == S_ACK || state == S_DONE) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl_gen.sv
// Testbench for intr_ctrl_gen: directed scenarios plus randomized rounds
// checked against a behavioural pending/arbitration model.
`timescale 1ns/1ps
`default_nettype none

module tb_intr_ctrl_gen;

    localparam int         N  = 8;
    localparam logic [4:0] VT = 5'b10011;
    localparam logic [4:0] ET = 5'b01100;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] intr_rq, mask_in, bus_in;
    logic       cmd_valid, intr_in;
    logic       intr_out, bus_oe, err;
    logic [7:0] bus_out, pending;

    intr_ctrl_gen #(
        .N_CH(8), .ID_W(3), .BUS_W(8),
        .VEC_TAG(5'b10011), .EOI_TAG(5'b01100), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_in(rst_in), .intr_rq(intr_rq), .mask_in(mask_in),
        .cmd_valid(cmd_valid), .bus_in(bus_in), .intr_in(intr_in),
        .intr_out(intr_out), .bus_out(bus_out), .bus_oe(bus_oe),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] m_pend, m_prev;
    int         m_rr;
    bit         m_pri;
    int         m_tbl [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the model applies the edge rules at the same edge as the DUT.
    task automatic step(input logic [7:0] clr);
        @(posedge clk);
        m_pend = (m_pend & ~clr) | (intr_rq & ~m_prev);
        m_prev = intr_rq;
        #1;
    endtask

    task automatic cmd(input logic [7:0] w);
        cmd_valid = 1'b1;
        bus_in    = w;
        step(8'h00);
        cmd_valid = 1'b0;
        bus_in    = 8'h00;
    endtask

    task automatic pulse(input logic [7:0] r);
        intr_rq = r;
        step(8'h00);
        intr_rq = 8'h00;
        step(8'h00);
    endtask

    function automatic int exp_win();
        logic [7:0] e;
        int         c;
        e = m_pend & ~mask_in;
        if (m_pri) begin
            for (int r = 0; r < N; r++) if (e[m_tbl[r]]) return m_tbl[r];
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (e[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic wait_dispatch();
        int n = 0;
        while (intr_out !== 1'b1 && n < 10) begin
            step(8'h00);
            n++;
        end
        chk("dispatch_seen", intr_out, 1);
    endtask

    task automatic serve(input int id);
        logic [2:0] id3;
        logic [7:0] one;
        id3 = id[2:0];
        one = 8'h01;
        wait_dispatch();
        intr_in = 1'b0;
        step(8'h00);
        chk("vec_bus_out", bus_out, {VT, id3});
        chk("ack_bus_oe", bus_oe, 1);
        chk("ack_intr_out", intr_out, 0);
        step(8'h00);
        chk("done_bus_oe", bus_oe, 0);
        chk("done_bus_out", bus_out, 0);
        cmd_valid = 1'b1;
        bus_in    = {ET, id3};
        step(one << id3);
        cmd_valid = 1'b0;
        bus_in    = 8'h00;
        intr_in   = 1'b1;
        if (!m_pri) m_rr = id;
        chk("eoi_err", err, 0);
        chk("pend_after_eoi", pending, m_pend);
    endtask

    task automatic load_table();
        logic [2:0] t;
        for (int r = 0; r < N; r++) begin
            t = m_tbl[r][2:0];
            cmd({3'b000, t, 2'b10});
        end
        m_pri = 1'b1;
    endtask

    task automatic rand_round();
        int w;
        mask_in = 8'hFF;
        pulse(8'($urandom_range(1, 255)));
        chk("rand_pend", pending, m_pend);
        mask_in = 8'($urandom());
        for (int i = 0; i < N; i++) begin
            w = exp_win();
            if (w < 0) begin
                step(8'h00);
                step(8'h00);
                chk("rand_idle", intr_out, 0);
                break;
            end
            serve(w);
        end
        mask_in = 8'hFF;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        rst_in = 1'b1; intr_rq = 8'h00; mask_in = 8'h00; bus_in = 8'h00;
        cmd_valid = 1'b0; intr_in = 1'b1;
        m_pend = 8'h00; m_prev = 8'h00; m_rr = N - 1; m_pri = 1'b0;
        for (int i = 0; i < N; i++) m_tbl[i] = i;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_intr_out", intr_out, 0);
        chk("rst_bus_oe", bus_oe, 0);
        chk("rst_bus_out", bus_out, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", err, 0);
        rst_in = 1'b0;
        step(8'h00);

        // Round-robin from the reset pointer, with request-to-interrupt latency
        cmd(8'h01);
        intr_rq = 8'h24;
        step(8'h00);
        chk("lat_pending", pending, 8'h24);
        chk("lat_intr_out_early", intr_out, 0);
        intr_rq = 8'h00;
        step(8'h00);
        chk("lat_intr_out", intr_out, 1);
        serve(2);
        serve(5);
        chk("rr_pend_clear", pending, 0);

        // Reversed priority table
        cmd(8'hFF);
        for (int i = 0; i < N; i++) m_tbl[i] = N - 1 - i;
        load_table();
        pulse(8'h81);
        serve(7);
        serve(0);

        // Mask blocks dispatch but not capture
        mask_in = 8'h04;
        pulse(8'h04);
        step(8'h00);
        chk("mask_pending", pending, 8'h04);
        chk("mask_intr_out", intr_out, 0);
        mask_in = 8'h00;
        step(8'h00);
        step(8'h00);
        chk("unmask_intr_out", intr_out, 1);
        serve(2);

        // Wrong EOI
        pulse(8'h08);
        wait_dispatch();
        intr_in = 1'b0;
        step(8'h00);
        chk("bad_vec", bus_out, {VT, 3'd3});
        step(8'h00);
        cmd_valid = 1'b1;
        bus_in    = 8'h64;
        step(8'h00);
        cmd_valid = 1'b0;
        bus_in    = 8'h00;
        intr_in   = 1'b1;
        chk("bad_eoi_err", err, 1);
        chk("bad_eoi_pending", pending, 8'h08);
        step(8'h00);
        chk("bad_eoi_err_pulse", err, 0);
        step(8'h00);
        step(8'h00);
        chk("bad_eoi_cfg_idle", intr_out, 0);
        cmd(8'h01);
        m_pri = 1'b0;
        serve(3);

        // Watchdog: no acknowledge for TIMEOUT cycles
        pulse(8'h40);
        wait_dispatch();
        repeat (63) step(8'h00);
        chk("wd_pre_intr_out", intr_out, 1);
        chk("wd_pre_err", err, 0);
        step(8'h00);
        chk("wd_intr_out", intr_out, 0);
        chk("wd_err", err, 1);
        chk("wd_pending_kept", pending, 8'h40);
        step(8'h00);
        chk("wd_reassert", intr_out, 1);
        chk("wd_err_pulse", err, 0);
        serve(6);

        // Return-to-CFG word wins over a ready dispatch
        mask_in = 8'hFF;
        pulse(8'h01);
        mask_in   = 8'h00;
        cmd_valid = 1'b1;
        bus_in    = 8'hFF;
        step(8'h00);
        cmd_valid = 1'b0;
        bus_in    = 8'h00;
        chk("cfg_prec_intr_out", intr_out, 0);
        step(8'h00);
        chk("cfg_idle_intr_out", intr_out, 0);
        cmd(8'h01);
        serve(0);

        // Randomized rounds in round-robin, then with a random table
        repeat (6) rand_round();
        cmd(8'hFF);
        for (int i = 0; i < N; i++) m_tbl[i] = $urandom_range(0, N - 1);
        load_table();
        repeat (6) rand_round();
        cmd(8'hFF);
        cmd(8'h01);
        m_pri   = 1'b0;
        mask_in = 8'h00;
        for (int i = 0; i < N; i++) begin
            w = exp_win();
            if (w < 0) break;
            serve(w);
        end
        chk("drain_pending", pending, 0);

        // Asynchronous reset during the vector cycle
        pulse(8'h10);
        wait_dispatch();
        intr_in = 1'b0;
        step(8'h00);
        chk("pre_rst_bus_oe", bus_oe, 1);
        rst_in = 1'b1;
        #1;
        chk("arst_bus_oe", bus_oe, 0);
        chk("arst_intr_out", intr_out, 0);
        chk("arst_pending", pending, 0);
        chk("arst_bus_out", bus_out, 0);
        m_pend = 8'h00; m_prev = 8'h00; m_rr = N - 1; m_pri = 1'b0;
        intr_in = 1'b1;
        step(8'h00);
        rst_in = 1'b0;
        step(8'h00);
        cmd(8'h01);
        pulse(8'h81);
        serve(0);
        serve(7);
        chk("final_pending", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
